// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and helpers for the N-to-2^N handshake decoder.
// Optional sweep feature is controlled by the DECODER_SWEEP_EN macro.
package decoder_pkg;

    // Sweep controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Output word width for an n-bit code.
    function automatic int out_width(input int n);
        return 1 << n;
    endfunction

endpackage : decoder_pkg

// File: rtl/decoder_nto2n_comb.sv
// decoder_nto2n_comb: purely combinational N-bit code + enable -> 2^N one-hot.
// Used by decoder_nto2n_hs (see DECODER_SWEEP_EN there for the sweep option).
module decoder_nto2n_comb
    import decoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              code,
    input  logic                      en,
    output logic [out_width(N)-1:0]   onehot
);

    // Set the single bit addressed by code, or nothing when disabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule : decoder_nto2n_comb

// File: rtl/decoder_nto2n_hs.sv
// decoder_nto2n_hs: registered N-to-2^N one-hot decoder with valid/ready
// handshakes on both sides and a single-entry output register.
// Define DECODER_SWEEP_EN to add the self-driven sweep controller
// (sweep_start / sweep_busy / sweep_done) that walks every output line once.
module decoder_nto2n_hs
    import decoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              in_code,
    input  logic                      en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [out_width(N)-1:0]   dout
`ifdef DECODER_SWEEP_EN
    ,
    input  logic                      sweep_start,
    output logic                      sweep_busy,
    output logic                      sweep_done
`endif
);

    localparam int W = out_width(N);

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  dout_q,      dout_d;
    logic          can_load;     // output register is free this cycle
    logic          sweep_issue;  // sweep controller writes the register this cycle
    logic          load;         // register takes a new decoded word
    logic [N-1:0]  sel_code;
    logic          sel_en;
    logic [W-1:0]  dec_word;

    assign can_load = !out_valid_q || out_ready;

`ifdef DECODER_SWEEP_EN
    state_e        state_q, state_d;
    logic [N-1:0]  cnt_q,   cnt_d;

    assign sweep_issue = (state_q == ST_SWEEP) && can_load;
    // Sweep request wins over an external code presented in the same cycle.
    assign in_ready    = (state_q == ST_IDLE) && !sweep_start && can_load;
    assign sel_code    = sweep_issue ? cnt_q : in_code;
    assign sel_en      = sweep_issue ? 1'b1  : en;
    assign sweep_busy  = (state_q == ST_SWEEP);
    assign sweep_done  = (state_q == ST_DONE);

    // Sweep controller next state: start, walk all codes, one-cycle DONE.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (can_load) begin
                    cnt_d = cnt_q + N'(1);
                    if (cnt_q == '1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sweep controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign sweep_issue = 1'b0;
    assign in_ready    = can_load;
    assign sel_code    = in_code;
    assign sel_en      = en;
`endif

    decoder_nto2n_comb #(
        .N (N)
    ) u_comb (
        .code   (sel_code),
        .en     (sel_en),
        .onehot (dec_word)
    );

    assign load = (in_valid && in_ready) || sweep_issue;

    // Output register next value: load, drain on consumer accept, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        if (load) begin
            out_valid_d = 1'b1;
            dout_d      = dec_word;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            dout_d      = '0;
        end
    end

    // Output register with synchronous reset; pending word is discarded on reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule : decoder_nto2n_hs

// File: tb/tb_decoder_nto2n_hs.sv
// Testbench for decoder_nto2n_hs (N = 4). Sweep scenarios compile only when
// DECODER_SWEEP_EN is defined.
module tb_decoder_nto2n_hs;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_code;
    logic          en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  dout;
`ifdef DECODER_SWEEP_EN
    logic          sweep_start;
    logic          sweep_busy;
    logic          sweep_done;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    decoder_nto2n_hs #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .en          (en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dout        (dout)
`ifdef DECODER_SWEEP_EN
        ,
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          in_valid;
        logic          en;
        logic [N-1:0]  code;
        logic          out_ready;
        logic          exp_ready;   // in_ready before the edge
        logic          exp_valid;   // out_valid after the edge
        logic [W-1:0]  exp_dout;    // dout after the edge
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one table record: drive, check in_ready, clock, check outputs.
    task automatic apply(input vec_t v, input int idx);
        in_valid  = v.in_valid;
        en        = v.en;
        in_code   = v.code;
        out_ready = v.out_ready;
        #1;
        check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'(v.exp_ready));
        tick();
        check($sformatf("vec%0d_out_valid", idx), 32'(out_valid), 32'(v.exp_valid));
        check($sformatf("vec%0d_dout", idx), 32'(dout), 32'(v.exp_dout));
    endtask

    function automatic logic [W-1:0] onehot_of(input int code);
        logic [W-1:0] one;
        one = 1;
        return one << code;
    endfunction

    initial begin
        vec_t v;
        logic          m_valid;
        logic [W-1:0]  m_dout;
        logic          m_ready;

        rst       = 1'b1;
        in_valid  = 1'b0;
        en        = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
`ifdef DECODER_SWEEP_EN
        sweep_start = 1'b0;
`endif

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef DECODER_SWEEP_EN
        check("reset_sweep_busy", 32'(sweep_busy), 32'd0);
        check("reset_sweep_done", 32'(sweep_done), 32'd0);
`endif

        // ---------------- vector table
        for (int i = 0; i < 16; i++) begin
            v = '{1'b1, 1'b1, N'(i), 1'b1, 1'b1, 1'b1, onehot_of(i)};
            tbl.push_back(v);
        end
        // en = 0 produces a valid all-zero word
        tbl.push_back('{1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 16'h0000});
        // code 3, then stall 5 cycles with code 7 waiting
        tbl.push_back('{1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 16'h0008});
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 16'h0008});
        end
        // release: code 7 accepted in the same cycle
        tbl.push_back('{1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 16'h0080});
        // drain
        tbl.push_back('{1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000});
        // idle with out_ready low: register empty, still ready
        tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // ---------------- randomized traffic against a behavioural model
        m_valid = 1'b0;
        m_dout  = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 3) != 0);
            in_code   = N'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            m_ready = !m_valid || out_ready;
            check("rand_in_ready", 32'(in_ready), 32'(m_ready));
            if (in_valid && m_ready) begin
                m_valid = 1'b1;
                m_dout  = en ? onehot_of(int'(in_code)) : '0;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_dout  = '0;
            end
            tick();
            check("rand_out_valid", 32'(out_valid), 32'(m_valid));
            check("rand_dout", 32'(dout), 32'(m_dout));
        end

        // ---------------- reset mid-transfer discards the pending word
        in_valid  = 1'b1;
        en        = 1'b1;
        in_code   = 4'd2;
        out_ready = 1'b0;
        tick();
        check("stall_before_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_xfer_valid", 32'(out_valid), 32'd0);
        check("rst_mid_xfer_dout", 32'(dout), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("after_rst_valid", 32'(out_valid), 32'd0);

`ifdef DECODER_SWEEP_EN
        begin
            int  done_cnt;
            int  busy_cnt;
            bit  found;

            // ---------------- full sweep with out_ready = 1
            done_cnt    = 0;
            busy_cnt    = 0;
            out_ready   = 1'b1;
            sweep_start = 1'b1;
            #1;
            check("sweep1_start_in_ready", 32'(in_ready), 32'd0);
            tick();
            sweep_start = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (sweep_busy) busy_cnt++;
                if (sweep_done) done_cnt++;
                tick();
                check($sformatf("sweep1_dout%0d", k), 32'(dout), 32'(onehot_of(k)));
                check($sformatf("sweep1_valid%0d", k), 32'(out_valid), 32'd1);
            end
            check("sweep1_busy_cycles", 32'(busy_cnt), 32'd16);
            check("sweep1_busy_end", 32'(sweep_busy), 32'd0);
            if (sweep_done) done_cnt++;
            check("sweep1_in_ready_done", 32'(in_ready), 32'd0);
            tick();
            if (sweep_done) done_cnt++;
            check("sweep1_done_pulses", 32'(done_cnt), 32'd1);
            check("sweep1_in_ready_back", 32'(in_ready), 32'd1);
            check("sweep1_drained", 32'(out_valid), 32'd0);

            // ---------------- sweep_start and in_valid together
            sweep_start = 1'b1;
            in_valid    = 1'b1;
            en          = 1'b1;
            in_code     = 4'd9;
            #1;
            check("sweep2_in_ready", 32'(in_ready), 32'd0);
            tick();
            sweep_start = 1'b0;
            check("sweep2_code9_not_taken", 32'(out_valid), 32'd0);
            check("sweep2_in_ready_busy", 32'(in_ready), 32'd0);
            tick();
            check("sweep2_first_dout", 32'(dout), 32'h0001);
            in_valid = 1'b0;
            found = 0;
            for (int c = 0; c < 40 && !found; c++) begin
                tick();
                if (sweep_done) found = 1;
            end
            check("sweep2_done_seen", 32'(found), 32'd1);
            tick();

            // ---------------- reset at sweep code 7 with out_ready toggling
            sweep_start = 1'b1;
            out_ready   = 1'b0;
            tick();
            sweep_start = 1'b0;
            found = 0;
            for (int c = 0; c < 60 && !found; c++) begin
                out_ready = ~out_ready;
                tick();
                if (out_valid && dout == 16'h0080) found = 1;
            end
            check("sweep3_reached_code7", 32'(found), 32'd1);
            rst       = 1'b1;
            out_ready = 1'b1;
            tick();
            check("sweep3_rst_valid", 32'(out_valid), 32'd0);
            check("sweep3_rst_dout", 32'(dout), 32'd0);
            check("sweep3_rst_busy", 32'(sweep_busy), 32'd0);
            check("sweep3_rst_done", 32'(sweep_done), 32'd0);
            rst = 1'b0;
            done_cnt = 0;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (sweep_done || sweep_busy || out_valid) done_cnt++;
            end
            check("sweep3_quiet_after_rst", 32'(done_cnt), 32'd0);
            sweep_start = 1'b1;
            tick();
            sweep_start = 1'b0;
            tick();
            check("sweep3_restart_dout", 32'(dout), 32'h0001);
            tick();
            check("sweep3_restart_dout2", 32'(dout), 32'h0002);
            found = 0;
            for (int c = 0; c < 40 && !found; c++) begin
                tick();
                if (sweep_done) found = 1;
            end
            check("sweep3_done_seen", 32'(found), 32'd1);
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_decoder_nto2n_hs

// File: doc/decoder_nto2n_hs.md
# decoder_nto2n_hs

Parametrised, registered N-to-2^N one-hot decoder with valid/ready handshakes on input and output, plus an optional self-driven sweep mode. It is the next generation of the team's fixed 4-to-16 structural decoder, which has no clock, no flow control and no enable. It sits between a code producer (address/select logic) and a consumer of one-hot selects, such as row drivers or bank enables. An internal counter can walk every output line in sequence for board bring-up and self-test.

## Interface
- N, default 4: input code width; output width is 2^N (N in 1..8).
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_code is valid this cycle.
- in_ready  out  1  block accepts in_code this cycle.
- in_code  in  N  binary code to decode.
- en  in  1  sampled with each accepted code; 0 gives an all-zero dout for that transfer.
- out_valid  out  1  dout holds a decoded word.
- out_ready  in  1  consumer accepts dout this cycle.
- dout  out  2^N  registered one-hot (or all-zero) word.
- sweep_start  in  1  request a sweep (DECODER_SWEEP_EN only).
- sweep_busy  out  1  sweep in progress (DECODER_SWEEP_EN only).
- sweep_done  out  1  one-cycle pulse at sweep completion (DECODER_SWEEP_EN only).

## Operation
- Single-entry output register.
- in_ready = (state == IDLE) && !sweep_start && (!out_valid || out_ready). This path is combinational.
- An input transfer happens when in_valid && in_ready. On a transfer:
  - dout <= en ? (1 << in_code) : 0
  - out_valid <= 1
- Output transfer: when out_valid && out_ready and no new input is accepted, out_valid <= 0 and dout <= 0.
- While out_valid && !out_ready, dout and out_valid hold stable.
- Sweep FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when sweep_start is high. Sweep takes priority over in_valid in the same cycle. cnt <= 0.
  - In SWEEP, the block self-issues code cnt with en = 1 whenever !out_valid || out_ready. It then increments cnt.
  - When code 2^N-1 is issued, cnt wraps to 0 and the state moves to DONE.
  - DONE -> IDLE after one cycle. sweep_done = 1 only in DONE.
- sweep_busy = (state == SWEEP).
- sweep_start is ignored outside IDLE.
- in_ready = 0 in SWEEP and DONE. External codes are never dropped; they are simply not accepted.

## Timing
- Reset values: out_valid = 0, dout = 0, sweep_busy = 0, sweep_done = 0, state = IDLE, cnt = 0. in_ready = 1 after reset unless sweep_start is high.
- Latency: a code accepted on edge k is visible on dout/out_valid after edge k.
- Throughput: one code per cycle with out_ready held high.
- Sweep: with out_ready = 1, codes appear on 2^N consecutive cycles. sweep_done pulses on the cycle after the last code is issued.
- Reset mid-sweep or mid-transfer: the next edge restores all reset values. There is no sweep_done pulse, and any pending dout is discarded.

## Configuration
- DECODER_SWEEP_EN defined:
  - FSM, counter, sweep_start, sweep_busy and sweep_done are present.
- DECODER_SWEEP_EN undefined:
  - The three sweep ports are absent.
  - State is permanently IDLE.
  - in_ready = !out_valid || out_ready.

## Structure
- decoder_pkg holds:
  - the state enum (IDLE, SWEEP, DONE) and its 2-bit encoding;
  - a localparam-style function giving output width 2^N.
- Sub-module decoder_nto2n_comb: purely combinational N-bit code + en -> 2^N one-hot. It is instantiated once, and its mux input is selected between in_code and cnt.

## Test plan
- Reset, then drive in_code 0..15 with en = 1 and out_ready = 1 (N = 4).
  - Required: dout = 16'h0001, 16'h0002, ... 16'h8000 on consecutive cycles, each one cycle after acceptance.
- en = 0, in_code = 4'd5.
  - Required: out_valid = 1, dout = 16'h0000.
- Present in_code = 4'd3, then hold out_ready = 0 for 5 cycles.
  - Required: dout holds 16'h0008 and in_ready = 0 throughout.
  - Then release: the next code is accepted in the same cycle as the release.
- DECODER_SWEEP_EN: pulse sweep_start with out_ready = 1.
  - Required: sweep_busy high for 16 cycles, dout walks 16'h0001..16'h8000, sweep_done pulses once, then in_ready returns high.
- Assert sweep_start and in_valid together (in_code = 4'd9).
  - Required: the sweep wins, in_ready = 0, and the first output is 16'h0001.
- Assert rst at sweep code 7, with out_ready toggling.
  - Required: out_valid = 0, dout = 0, sweep_busy = 0, no sweep_done pulse, cnt = 0; a new sweep restarts at 16'h0001.
